// File: rtl/pc_branch_redirect_pkg.sv
// Shared fetch-pipeline definitions: NOP encoding, redirect FSM states, PC step.
package pc_branch_redirect_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } redir_state_e;
endpackage

// File: rtl/pc_branch_redirect_ifid_reg.sv
// Generic stage register: kill beats hold; kill clears instr/valid and keeps pc4.
module pc_branch_redirect_ifid_reg
  import pc_branch_redirect_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_hold,
  input  logic             i_kill,
  input  logic [WIDTH-1:0] i_instr,
  input  logic [WIDTH-1:0] i_pc4,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pc4,
  output logic             o_valid
);
  logic [WIDTH-1:0] r_instr, r_pc4;
  logic             r_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_instr <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_kill) begin
      r_instr <= WIDTH'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;
endmodule

// File: rtl/pc_branch_redirect.sv
// Fetch-side PC owner: applies EX branch / ID jump redirects and inserts refetch bubbles.
module pc_branch_redirect
  import pc_branch_redirect_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               FLUSH_SLOTS = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic [WIDTH-1:0] i_imem_data,
  output logic [WIDTH-1:0] o_imem_addr,
  output logic [WIDTH-1:0] o_ifid_instr,
  output logic [WIDTH-1:0] o_ifid_pc4,
  output logic             o_ifid_valid,
  output logic             o_redirect_busy,
  output logic             o_misalign_err
);
  localparam logic [1:0] SLOTS = FLUSH_SLOTS[1:0];

  redir_state_e     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [1:0]       r_cnt;
  logic             r_misalign;

  logic             w_redirect, w_flush;
  logic [WIDTH-1:0] w_target, w_pc4;

  // The branch in EX is older than the jump in ID, so it wins.
  assign w_redirect = i_branch_taken | i_jump;
  assign w_target   = i_branch_taken ? i_branch_target : i_jump_target;
  assign w_pc4      = r_pc + WIDTH'(PC_INC);
  assign w_flush    = (r_state == ST_FLUSH);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= {w_target[WIDTH-1:2], 2'b00};
      r_misalign <= |w_target[1:0];
      if (SLOTS == 2'd0) begin
        r_state <= ST_RUN;
        r_cnt   <= '0;
      end else begin
        r_state <= ST_FLUSH;
        r_cnt   <= SLOTS;
      end
    end else begin
      r_misalign <= 1'b0;
      if (w_flush) begin
        // Bubbles are time-based, so the count runs down even under stall.
        r_cnt <= r_cnt - 2'd1;
        if (r_cnt <= 2'd1) r_state <= ST_RUN;
      end else if (!i_stall) begin
        r_pc <= w_pc4;
      end
    end
  end

  pc_branch_redirect_ifid_reg #(.WIDTH(WIDTH)) u_ifid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_hold  (i_stall),
    .i_kill  (w_redirect | w_flush),
    .i_instr (i_imem_data),
    .i_pc4   (w_pc4),
    .o_instr (o_ifid_instr),
    .o_pc4   (o_ifid_pc4),
    .o_valid (o_ifid_valid)
  );

  assign o_imem_addr     = r_pc;
  assign o_redirect_busy = w_flush;
  assign o_misalign_err  = r_misalign;
endmodule

// File: tb/tb_pc_branch_redirect.sv
// Directed bench for pc_branch_redirect with FLUSH_SLOTS=1 and hand-computed expectations.
module tb_pc_branch_redirect;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target, imem_data;
  logic [31:0] imem_addr, ifid_instr, ifid_pc4;
  logic        ifid_valid, redirect_busy, misalign_err;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pc_branch_redirect #(.WIDTH(32), .RESET_PC(32'h0), .FLUSH_SLOTS(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall),
    .i_branch_taken(branch_taken), .i_branch_target(branch_target),
    .i_jump(jump), .i_jump_target(jump_target), .i_imem_data(imem_data),
    .o_imem_addr(imem_addr), .o_ifid_instr(ifid_instr), .o_ifid_pc4(ifid_pc4),
    .o_ifid_valid(ifid_valid), .o_redirect_busy(redirect_busy),
    .o_misalign_err(misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] a, input logic [31:0] i,
                        input logic [31:0] p, input logic v, input logic b, input logic m);
    chk({tag, ".addr"},  imem_addr, a);
    chk({tag, ".instr"}, ifid_instr, i);
    chk({tag, ".pc4"},   ifid_pc4, p);
    chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, v});
    chk({tag, ".busy"},  {31'b0, redirect_busy}, {31'b0, b});
    chk({tag, ".mis"},   {31'b0, misalign_err}, {31'b0, m});
  endtask

  initial begin
    reset = 1; stall = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0; imem_data = 0;
    tick();
    chk_if("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    reset = 0;

    // free-running fetch
    imem_data = 32'h11; tick(); chk_if("run0", 32'h4, 32'h11, 32'h4, 1, 0, 0);
    imem_data = 32'h22; tick(); chk_if("run1", 32'h8, 32'h22, 32'h8, 1, 0, 0);

    // stall two cycles at pc=8
    stall = 1; imem_data = 32'h33;
    tick(); chk_if("stall0", 32'h8, 32'h22, 32'h8, 1, 0, 0);
    tick(); chk_if("stall1", 32'h8, 32'h22, 32'h8, 1, 0, 0);
    stall = 0;
    tick(); chk_if("resume", 32'hC, 32'h33, 32'hC, 1, 0, 0);

    // branch and jump together: branch wins
    branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80; imem_data = 32'h44;
    tick(); chk_if("both", 32'h40, 32'h0, 32'hC, 0, 1, 0);
    branch_taken = 0; jump = 0; imem_data = 32'h55;
    tick(); chk_if("flush", 32'h40, 32'h0, 32'hC, 0, 0, 0);
    tick(); chk_if("tgt", 32'h44, 32'h55, 32'h44, 1, 0, 0);

    // redirect under stall, then flush counts down while still stalled
    stall = 1; jump = 1; jump_target = 32'h100;
    tick(); chk_if("stjmp", 32'h100, 32'h0, 32'h44, 0, 1, 0);
    jump = 0;
    tick(); chk_if("stflush", 32'h100, 32'h0, 32'h44, 0, 0, 0);
    stall = 0; imem_data = 32'h66;
    tick(); chk_if("stres", 32'h104, 32'h66, 32'h104, 1, 0, 0);

    // misaligned branch target
    branch_taken = 1; branch_target = 32'h43;
    tick(); chk_if("mis0", 32'h40, 32'h0, 32'h104, 0, 1, 1);
    branch_taken = 0;
    tick(); chk_if("mis1", 32'h40, 32'h0, 32'h104, 0, 0, 0);
    tick(); chk_if("mis2", 32'h44, 32'h66, 32'h44, 1, 0, 0);

    // pc wrap at the top of the address space
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick(); chk_if("wrap0", 32'hFFFF_FFFC, 32'h0, 32'h44, 0, 1, 0);
    jump = 0;
    tick(); imem_data = 32'h77;
    tick(); chk_if("wrap1", 32'h0, 32'h77, 32'h0, 1, 0, 0);

    // reset during flush discards the redirect
    jump = 1; jump_target = 32'h200;
    tick(); chk_if("rflush", 32'h200, 32'h0, 32'h0, 0, 1, 0);
    jump = 0; reset = 1; imem_data = 32'h88;
    tick(); chk_if("rst2", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    reset = 0;
    tick(); chk_if("post", 32'h4, 32'h88, 32'h4, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_branch_redirect.md
Name: pc_branch_redirect

Overview:
- Fetch-side consumer of the branch-target adder result (SaltosALU) and of jump targets.
- Owns the program counter and the IF/ID pipeline register.
- Applies redirects from EX (taken branch) and ID (jump), kills wrong-path fetches, and inserts a configurable number of refetch bubbles after each redirect.
- Sits between the instruction memory and the decode stage of the pipeline.

Parameters:
- WIDTH, 32, address/instruction width in bits.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- FLUSH_SLOTS, 1, bubble cycles after a redirect before fetch resumes (0 to 3 legal).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold request; freezes PC and IF/ID.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  WIDTH  branch target (SaltosALU ALUResult).
- jump  in  1  ID-stage jump decoded.
- jump_target  in  WIDTH  jump target address.
- imem_data  in  WIDTH  instruction at imem_addr; combinational read, valid in the same cycle.
- imem_addr  out  WIDTH  current PC, driven to instruction memory.
- ifid_instr  out  WIDTH  registered instruction for decode.
- ifid_pc4  out  WIDTH  registered PC+4 for decode.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble/NOP).
- redirect_busy  out  1  high while in FLUSH.
- misalign_err  out  1  one-cycle pulse when an accepted target has bits [1:0] != 0.

Behaviour:
- Reset (clk edge with reset=1), dominates all other inputs:
  - pc = RESET_PC; ifid_instr = 0; ifid_pc4 = 0; ifid_valid = 0.
  - state = RUN; flush counter = 0; misalign_err = 0.
- imem_addr = pc, combinationally.
- FSM states: RUN, FLUSH.
- Redirect:
  - A redirect occurs when branch_taken=1 or jump=1.
  - If both are asserted, branch_taken wins, because the EX instruction is older.
- Priority in every state: reset > redirect > stall > normal.
- RUN, normal (no redirect, stall=0):
  - ifid_instr <= imem_data; ifid_pc4 <= pc+4; ifid_valid <= 1; pc <= pc+4.
- RUN, stall=1 with no redirect:
  - pc and all ifid_* hold their values.
- Redirect, accepted in any state and even while stall=1:
  - pc <= target with bits [1:0] forced to 00.
  - ifid_instr <= 0; ifid_valid <= 0; ifid_pc4 holds.
  - misalign_err <= 1 if target[1:0] != 0, else 0.
  - If FLUSH_SLOTS=0, stay in or return to RUN; fetch of the target occurs on the next cycle.
  - Otherwise go to FLUSH with counter <= FLUSH_SLOTS.
- FLUSH (redirect_busy=1):
  - pc holds; ifid_valid=0; ifid_instr=0.
  - Counter decrements every cycle regardless of stall.
  - When the counter reaches 1, the next state is RUN.
  - A new redirect in FLUSH reloads the counter and the pc.
- misalign_err is 0 in every cycle without a misaligned redirect.
- Arithmetic:
  - pc+4 is modulo 2^WIDTH; 32'hFFFFFFFC wraps to 0 with no flag.
  - ifid_pc4 wraps the same way.
- Redirect latency: target appears on imem_addr one cycle after the redirect edge. The first valid target instruction appears in IF/ID after FLUSH_SLOTS+1 further edges.
- Reset asserted mid-FLUSH: immediate return to the reset state; the pending redirect is discarded.

Decomposition:
- Shared pipeline package holds:
  - the NOP encoding (32'h00000000);
  - the state encoding (RUN=1'b0, FLUSH=1'b1);
  - the PC increment constant (4).
- One natural sub-module: ifid_reg, the IF/ID register with hold (stall) and clear (kill) controls. It is reusable for other stage registers.
- The PC/FSM logic stays in the top module.

Test Plan:
- Reset then 3 free-running cycles, imem_data = 0x11, 0x22, 0x33:
  - imem_addr goes 0, 4, 8, 0xC.
  - ifid_pc4 goes 4, 8, 0xC with ifid_valid=1 from the first edge.
- Stall for 2 cycles at pc=8:
  - imem_addr stays 8.
  - ifid_instr/ifid_pc4 hold their values.
  - Resumes at 0xC after stall drops.
- branch_taken with branch_target=0x40 and jump with jump_target=0x80 in the same cycle, FLUSH_SLOTS=1:
  - pc=0x40; ifid_valid=0 for 2 edges; redirect_busy high for 1 cycle.
  - ifid_pc4=0x44 with valid=1 afterwards.
- Redirect asserted with stall=1, jump_target=0x100:
  - pc becomes 0x100 despite stall; IF/ID killed.
- branch_target=0x43:
  - pc=0x40; misalign_err pulses for exactly one cycle.
- pc forced to 0xFFFFFFFC via jump:
  - Next fetch address is 0x00000000; ifid_pc4=0.
  - Reset asserted during FLUSH returns pc to RESET_PC with ifid_valid=0.
